spr_rename_file: RTL and testbench

- Parametrised special-purpose register file with reservation-station tag renaming for the out-of-order PowerPC core; holds XER, LR and CTR.
- Multiple result-bus write ports, multiple dispatch update ports and optional same-cycle write-to-read bypass.
- Per-port illegal-SPR flags feed the exception logic.
- Pipeline flush drops all pending tags.
- Sits between decode/dispatch (read, update) and the common data bus (write).

---
 rtl/ppc_types.sv | 33 +++
 rtl/spr_rename_file_if.sv | 46 ++++
 rtl/spr_addr_decode.sv | 16 +
 rtl/spr_rename_file.sv | 130 +++++++++++++
 tb/tb_spr_rename_file.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ppc_types.sv
// Shared SPR definitions for the out-of-order PowerPC core: architected SPR
// numbers, storage slot mapping and the lookup helper used by every decoder.
package ppc_types;

  localparam logic [9:0] SPR_XER = 10'd1;
  localparam logic [9:0] SPR_LR  = 10'd8;
  localparam logic [9:0] SPR_CTR = 10'd9;

  localparam int NUM_SPR   = 3;
  localparam int SPR_IDX_W = 2;

  typedef logic [SPR_IDX_W-1:0] spr_idx_t;

  typedef struct packed {
    logic     hit;
    spr_idx_t index;
  } spr_lookup_t;

  // Maps an architected SPR number onto its storage slot; hit=0 for any SPR
  // this file does not implement.
  function automatic spr_lookup_t spr_index(input logic [9:0] addr);
    spr_lookup_t lookup;
    lookup = '0;
    case (addr)
      SPR_XER: begin lookup.hit = 1'b1; lookup.index = spr_idx_t'(0); end
      SPR_LR:  begin lookup.hit = 1'b1; lookup.index = spr_idx_t'(1); end
      SPR_CTR: begin lookup.hit = 1'b1; lookup.index = spr_idx_t'(2); end
      default: lookup = '0;
    endcase
    return lookup;
  endfunction

endpackage

// File: rtl/spr_rename_file_if.sv
// Dispatch/CDB bundle for the SPR rename file; master is the pipeline side,
// slave is the register file.
interface spr_rename_file_if #(
  parameter int READ_PORTS   = 2,
  parameter int WRITE_PORTS  = 2,
  parameter int UPDATE_PORTS = 1,
  parameter int RS_ID_WIDTH  = 5
);

  logic                   flush;

  logic [9:0]             read_addr        [READ_PORTS];
  logic                   read_value_valid [READ_PORTS];
  logic [31:0]            read_value       [READ_PORTS];
  logic [RS_ID_WIDTH-1:0] read_rs_id       [READ_PORTS];
  logic                   read_addr_err    [READ_PORTS];

  logic                   write_enable     [WRITE_PORTS];
  logic [9:0]             write_addr       [WRITE_PORTS];
  logic [31:0]            write_value      [WRITE_PORTS];
  logic [RS_ID_WIDTH-1:0] write_rs_id      [WRITE_PORTS];

  logic                   update_enable    [UPDATE_PORTS];
  logic [9:0]             update_addr      [UPDATE_PORTS];
  logic [RS_ID_WIDTH-1:0] update_rs_id     [UPDATE_PORTS];
  logic                   update_addr_err  [UPDATE_PORTS];

  modport master (
    output flush,
    output read_addr,
    input  read_value_valid, read_value, read_rs_id, read_addr_err,
    output write_enable, write_addr, write_value, write_rs_id,
    output update_enable, update_addr, update_rs_id,
    input  update_addr_err
  );

  modport slave (
    input  flush,
    input  read_addr,
    output read_value_valid, read_value, read_rs_id, read_addr_err,
    input  write_enable, write_addr, write_value, write_rs_id,
    input  update_enable, update_addr, update_rs_id,
    output update_addr_err
  );

endinterface

// File: rtl/spr_addr_decode.sv
// Decodes a 10-bit SPR number into {hit, storage index}; one instance per port.
module spr_addr_decode
  import ppc_types::*;
(
  input  logic [9:0] addr,
  output logic       hit,
  output spr_idx_t   index
);

  spr_lookup_t lookup;

  assign lookup = spr_index(addr);
  assign hit    = lookup.hit;
  assign index  = lookup.index;

endmodule

// File: rtl/spr_rename_file.sv
// XER/LR/CTR register file with reservation-station tag renaming, CDB write
// capture, optional same-cycle bypass and flush of pending renames.
module spr_rename_file
  import ppc_types::*;
#(
  parameter int READ_PORTS   = 2,
  parameter int WRITE_PORTS  = 2,
  parameter int UPDATE_PORTS = 1,
  parameter int RS_ID_WIDTH  = 5,
  parameter int BYPASS       = 1
) (
  input  logic             clk,
  input  logic             rst,
  spr_rename_file_if.slave bus
);

  typedef struct packed {
    logic                   value_valid;
    logic [31:0]            value;
    logic [RS_ID_WIDTH-1:0] rs_id;
  } spr_entry_t;

  spr_entry_t entry_reg  [NUM_SPR];
  spr_entry_t entry_next [NUM_SPR];

  logic     write_hit  [WRITE_PORTS];
  spr_idx_t write_idx  [WRITE_PORTS];
  logic     update_hit [UPDATE_PORTS];
  spr_idx_t update_idx [UPDATE_PORTS];

  genvar gi;

  generate
    for (gi = 0; gi < WRITE_PORTS; gi++) begin : g_write_dec
      spr_addr_decode u_dec (
        .addr  (bus.write_addr[gi]),
        .hit   (write_hit[gi]),
        .index (write_idx[gi])
      );
    end

    for (gi = 0; gi < UPDATE_PORTS; gi++) begin : g_update_dec
      spr_addr_decode u_dec (
        .addr  (bus.update_addr[gi]),
        .hit   (update_hit[gi]),
        .index (update_idx[gi])
      );
      assign bus.update_addr_err[gi] = bus.update_enable[gi] & ~update_hit[gi];
    end
  endgenerate

  // Matching is always against the registered entry, so a write and an update
  // in the same cycle never chain: the write stores its value, the update then
  // overrides valid and tag.
  always_comb begin
    for (int e = 0; e < NUM_SPR; e++) begin
      entry_next[e] = entry_reg[e];
      // Descending scan lets the lowest-index matching CDB port win.
      for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
        if (bus.write_enable[w] && write_hit[w] && (write_idx[w] == spr_idx_t'(e)) &&
            !entry_reg[e].value_valid && (bus.write_rs_id[w] == entry_reg[e].rs_id)) begin
          entry_next[e].value       = bus.write_value[w];
          entry_next[e].value_valid = 1'b1;
        end
      end
      if (bus.flush) begin
        entry_next[e].value_valid = 1'b1;
      end else begin
        // Ascending scan: the youngest (highest-index) rename wins.
        for (int u = 0; u < UPDATE_PORTS; u++) begin
          if (bus.update_enable[u] && update_hit[u] && (update_idx[u] == spr_idx_t'(e))) begin
            entry_next[e].value_valid = 1'b0;
            entry_next[e].rs_id       = bus.update_rs_id[u];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_SPR; e++) begin
        entry_reg[e].value_valid <= 1'b1;
        entry_reg[e].value       <= '0;
        entry_reg[e].rs_id       <= '0;
      end
    end else begin
      entry_reg <= entry_next;
    end
  end

  generate
    for (gi = 0; gi < READ_PORTS; gi++) begin : g_read
      logic       hit;
      spr_idx_t   idx;
      spr_entry_t sel;

      spr_addr_decode u_dec (
        .addr  (bus.read_addr[gi]),
        .hit   (hit),
        .index (idx)
      );

      always_comb begin
        sel = '0;
        for (int e = 0; e < NUM_SPR; e++) begin
          if (hit && (idx == spr_idx_t'(e))) begin
            sel = entry_reg[e];
          end
        end
        // Bypass looks at the pre-update entry; same-cycle renames are not seen.
        if ((BYPASS != 0) && hit && !sel.value_valid) begin
          for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
            if (bus.write_enable[w] && (bus.write_addr[w] == bus.read_addr[gi]) &&
                (bus.write_rs_id[w] == sel.rs_id)) begin
              sel.value_valid = 1'b1;
              sel.value       = bus.write_value[w];
            end
          end
        end
      end

      assign bus.read_value_valid[gi] = sel.value_valid;
      assign bus.read_value[gi]       = sel.value;
      assign bus.read_rs_id[gi]       = sel.rs_id;
      assign bus.read_addr_err[gi]    = ~hit;
    end
  endgenerate

endmodule

// File: tb/tb_spr_rename_file.sv
// Self-checking bench for spr_rename_file: directed scenarios plus a random
// run compared against an array-based model of the SPR rename rules.
module tb_spr_rename_file;

  localparam int RP = 3;
  localparam int WP = 2;
  localparam int UP = 2;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spr_rename_file_if #(.READ_PORTS(RP), .WRITE_PORTS(WP), .UPDATE_PORTS(UP), .RS_ID_WIDTH(RW)) bus ();

  spr_rename_file #(
    .READ_PORTS(RP), .WRITE_PORTS(WP), .UPDATE_PORTS(UP), .RS_ID_WIDTH(RW), .BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, slot 0=XER, 1=LR, 2=CTR.
  bit          m_valid [3];
  logic [31:0] m_val   [3];
  logic [RW-1:0] m_rs  [3];

  function automatic int slot(input logic [9:0] a);
    if (a == 10'd1) return 0;
    if (a == 10'd8) return 1;
    if (a == 10'd9) return 2;
    return -1;
  endfunction

  function automatic void model_read(input logic [9:0] a, output logic v, output logic [31:0] d,
                                     output logic [RW-1:0] t, output logic err);
    int s;
    s = slot(a);
    v = 1'b0; d = '0; t = '0; err = (s < 0);
    if (s >= 0) begin
      v = m_valid[s]; d = m_val[s]; t = m_rs[s];
      if (!m_valid[s]) begin
        for (int w = 0; w < WP; w++) begin
          if (bus.write_enable[w] && bus.write_addr[w] == a && bus.write_rs_id[w] == m_rs[s]) begin
            v = 1'b1; d = bus.write_value[w];
            break;
          end
        end
      end
    end
  endfunction

  task automatic idle();
    bus.flush = 1'b0;
    for (int r = 0; r < RP; r++) bus.read_addr[r] = 10'd0;
    for (int w = 0; w < WP; w++) begin
      bus.write_enable[w] = 1'b0; bus.write_addr[w] = '0; bus.write_value[w] = '0; bus.write_rs_id[w] = '0;
    end
    for (int u = 0; u < UP; u++) begin
      bus.update_enable[u] = 1'b0; bus.update_addr[u] = '0; bus.update_rs_id[u] = '0;
    end
  endtask

  // Advances one clock, applying the model rules to the inputs present before the edge.
  task automatic tick();
    bit nv [3];
    logic [31:0] nval [3];
    logic [RW-1:0] nrs [3];
    for (int e = 0; e < 3; e++) begin nv[e] = m_valid[e]; nval[e] = m_val[e]; nrs[e] = m_rs[e]; end
    if (rst) begin
      for (int e = 0; e < 3; e++) begin nv[e] = 1'b1; nval[e] = '0; nrs[e] = '0; end
    end else begin
      for (int e = 0; e < 3; e++) begin
        for (int w = 0; w < WP; w++) begin
          if (bus.write_enable[w] && slot(bus.write_addr[w]) == e && !m_valid[e] &&
              bus.write_rs_id[w] == m_rs[e]) begin
            nval[e] = bus.write_value[w]; nv[e] = 1'b1;
            break;
          end
        end
        if (bus.flush) nv[e] = 1'b1;
        else begin
          for (int u = UP - 1; u >= 0; u--) begin
            if (bus.update_enable[u] && slot(bus.update_addr[u]) == e) begin
              nv[e] = 1'b0; nrs[e] = bus.update_rs_id[u];
              break;
            end
          end
        end
      end
    end
    @(posedge clk);
    for (int e = 0; e < 3; e++) begin m_valid[e] = nv[e]; m_val[e] = nval[e]; m_rs[e] = nrs[e]; end
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] spr_nums [3];
    spr_nums[0] = 10'd1; spr_nums[1] = 10'd8; spr_nums[2] = 10'd9;
    idle();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int r = 0; r < RP; r++) bus.read_addr[r] = spr_nums[r];
    #1;
    for (int r = 0; r < RP; r++) begin
      $display("txn reset read spr %0d: valid=%b value=%h rs=%0d err=%b", spr_nums[r],
               bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r], bus.read_addr_err[r]);
      n_checks++;
      if (bus.read_value_valid[r] !== 1'b1 || bus.read_value[r] !== 32'h0 ||
          bus.read_rs_id[r] !== 5'd0 || bus.read_addr_err[r] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_entry spr %0d: got valid=%b value=%h rs=%0d err=%b, expected 1/0/0/0",
                 spr_nums[r], bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r], bus.read_addr_err[r]);
      end
    end
    bus.read_addr[0] = 10'd5;
    #1;
    $display("txn reset read spr 5: valid=%b err=%b", bus.read_value_valid[0], bus.read_addr_err[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b0 || bus.read_addr_err[0] !== 1'b1 ||
        bus.read_value[0] !== 32'h0 || bus.read_rs_id[0] !== 5'd0) begin
      n_fail++;
      $display("FAIL unimpl_read: got valid=%b err=%b value=%h rs=%0d, expected 0/1/0/0",
               bus.read_value_valid[0], bus.read_addr_err[0], bus.read_value[0], bus.read_rs_id[0]);
    end
  endtask

  task automatic test_bypass();
    idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd8; bus.update_rs_id[0] = 5'd3;
    tick(); idle();
    bus.read_addr[0] = 10'd8;
    #1;
    $display("txn update LR tag 3: valid=%b rs=%0d", bus.read_value_valid[0], bus.read_rs_id[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b0 || bus.read_rs_id[0] !== 5'd3) begin
      n_fail++;
      $display("FAIL lr_pending: got valid=%b rs=%0d, expected 0/3", bus.read_value_valid[0], bus.read_rs_id[0]);
    end
    bus.write_enable[0] = 1'b1; bus.write_addr[0] = 10'd8; bus.write_rs_id[0] = 5'd3;
    bus.write_value[0] = 32'hDEADBEEF;
    #1;
    $display("txn bypass LR: valid=%b value=%h rs=%0d", bus.read_value_valid[0], bus.read_value[0], bus.read_rs_id[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b1 || bus.read_value[0] !== 32'hDEADBEEF || bus.read_rs_id[0] !== 5'd3) begin
      n_fail++;
      $display("FAIL lr_bypass: got valid=%b value=%h rs=%0d, expected 1/deadbeef/3",
               bus.read_value_valid[0], bus.read_value[0], bus.read_rs_id[0]);
    end
    tick(); idle(); bus.read_addr[0] = 10'd8;
    #1;
    $display("txn stored LR: valid=%b value=%h", bus.read_value_valid[0], bus.read_value[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b1 || bus.read_value[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL lr_stored: got valid=%b value=%h, expected 1/deadbeef", bus.read_value_valid[0], bus.read_value[0]);
    end
  endtask

  task automatic test_stale_tag();
    idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd9; bus.update_rs_id[0] = 5'd4;
    tick();
    bus.update_rs_id[0] = 5'd7;
    tick(); idle();
    bus.write_enable[0] = 1'b1; bus.write_addr[0] = 10'd9; bus.write_rs_id[0] = 5'd4; bus.write_value[0] = 32'h11;
    tick(); idle(); bus.read_addr[1] = 10'd9;
    #1;
    $display("txn stale CTR write: valid=%b value=%h rs=%0d", bus.read_value_valid[1], bus.read_value[1], bus.read_rs_id[1]);
    n_checks++;
    if (bus.read_value_valid[1] !== 1'b0 || bus.read_rs_id[1] !== 5'd7 || bus.read_value[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL ctr_stale: got valid=%b value=%h rs=%0d, expected 0/0/7",
               bus.read_value_valid[1], bus.read_value[1], bus.read_rs_id[1]);
    end
    bus.write_enable[1] = 1'b1; bus.write_addr[1] = 10'd9; bus.write_rs_id[1] = 5'd7; bus.write_value[1] = 32'h22;
    tick(); idle(); bus.read_addr[1] = 10'd9;
    #1;
    $display("txn current CTR write: valid=%b value=%h", bus.read_value_valid[1], bus.read_value[1]);
    n_checks++;
    if (bus.read_value_valid[1] !== 1'b1 || bus.read_value[1] !== 32'h22) begin
      n_fail++;
      $display("FAIL ctr_write: got valid=%b value=%h, expected 1/22", bus.read_value_valid[1], bus.read_value[1]);
    end
  endtask

  task automatic test_write_update_same_cycle();
    idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd1; bus.update_rs_id[0] = 5'd1;
    tick();
    bus.update_rs_id[0] = 5'd2;
    bus.write_enable[0] = 1'b1; bus.write_addr[0] = 10'd1; bus.write_rs_id[0] = 5'd1; bus.write_value[0] = 32'h5;
    tick(); idle(); bus.read_addr[2] = 10'd1;
    #1;
    $display("txn XER write+update: valid=%b value=%h rs=%0d", bus.read_value_valid[2], bus.read_value[2], bus.read_rs_id[2]);
    n_checks++;
    if (bus.read_value_valid[2] !== 1'b0 || bus.read_rs_id[2] !== 5'd2 || bus.read_value[2] !== 32'h5) begin
      n_fail++;
      $display("FAIL xer_update_wins: got valid=%b value=%h rs=%0d, expected 0/5/2",
               bus.read_value_valid[2], bus.read_value[2], bus.read_rs_id[2]);
    end
  endtask

  task automatic test_port_priority();
    idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd8; bus.update_rs_id[0] = 5'd5;
    bus.update_enable[1] = 1'b1; bus.update_addr[1] = 10'd8; bus.update_rs_id[1] = 5'd6;
    tick(); idle(); bus.read_addr[0] = 10'd8;
    #1;
    $display("txn dual update LR: valid=%b rs=%0d", bus.read_value_valid[0], bus.read_rs_id[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b0 || bus.read_rs_id[0] !== 5'd6) begin
      n_fail++;
      $display("FAIL update_priority: got valid=%b rs=%0d, expected 0/6", bus.read_value_valid[0], bus.read_rs_id[0]);
    end
    for (int w = 0; w < WP; w++) begin
      bus.write_enable[w] = 1'b1; bus.write_addr[w] = 10'd8; bus.write_rs_id[w] = 5'd6;
    end
    bus.write_value[0] = 32'hA; bus.write_value[1] = 32'hB;
    #1;
    n_checks++;
    if (bus.read_value[0] !== 32'hA || bus.read_value_valid[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_priority: got valid=%b value=%h, expected 1/a", bus.read_value_valid[0], bus.read_value[0]);
    end
    tick(); idle(); bus.read_addr[0] = 10'd8;
    #1;
    $display("txn dual write LR: valid=%b value=%h", bus.read_value_valid[0], bus.read_value[0]);
    n_checks++;
    if (bus.read_value_valid[0] !== 1'b1 || bus.read_value[0] !== 32'hA) begin
      n_fail++;
      $display("FAIL write_priority: got valid=%b value=%h, expected 1/a", bus.read_value_valid[0], bus.read_value[0]);
    end
  endtask

  task automatic test_flush_reset_err();
    logic [31:0] exp_val [3];
    logic [RW-1:0] exp_rs [3];
    exp_val[0] = 32'h5;  exp_rs[0] = 5'd9;
    exp_val[1] = 32'h77; exp_rs[1] = 5'd10;
    exp_val[2] = 32'h22; exp_rs[2] = 5'd11;
    idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd1; bus.update_rs_id[0] = 5'd9;
    bus.update_enable[1] = 1'b1; bus.update_addr[1] = 10'd8; bus.update_rs_id[1] = 5'd10;
    tick(); idle();
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd9; bus.update_rs_id[0] = 5'd11;
    tick(); idle();
    bus.flush = 1'b1;
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd1; bus.update_rs_id[0] = 5'd20;
    bus.write_enable[0] = 1'b1; bus.write_addr[0] = 10'd8; bus.write_rs_id[0] = 5'd10; bus.write_value[0] = 32'h77;
    tick(); idle();
    bus.read_addr[0] = 10'd1; bus.read_addr[1] = 10'd8; bus.read_addr[2] = 10'd9;
    #1;
    for (int r = 0; r < RP; r++) begin
      $display("txn flush read port %0d: valid=%b value=%h rs=%0d", r, bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r]);
      n_checks++;
      if (bus.read_value_valid[r] !== 1'b1 || bus.read_value[r] !== exp_val[r] || bus.read_rs_id[r] !== exp_rs[r]) begin
        n_fail++;
        $display("FAIL flush_entry %0d: got valid=%b value=%h rs=%0d, expected 1/%h/%0d", r,
                 bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r], exp_val[r], exp_rs[r]);
      end
    end
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd1; bus.update_rs_id[0] = 5'd3;
    tick();
    bus.update_enable[0] = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.update_enable[0] = 1'b1; bus.update_addr[0] = 10'd300; bus.update_rs_id[0] = 5'd12;
    #1;
    $display("txn update SPR 300: err0=%b err1=%b", bus.update_addr_err[0], bus.update_addr_err[1]);
    n_checks++;
    if (bus.update_addr_err[0] !== 1'b1 || bus.update_addr_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL update_err: got %b%b, expected 1 on port 0 and 0 on idle port 1",
               bus.update_addr_err[0], bus.update_addr_err[1]);
    end
    tick(); idle();
    bus.read_addr[0] = 10'd1; bus.read_addr[1] = 10'd8; bus.read_addr[2] = 10'd9;
    #1;
    for (int r = 0; r < RP; r++) begin
      $display("txn post-reset read port %0d: valid=%b value=%h rs=%0d", r, bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r]);
      n_checks++;
      if (bus.read_value_valid[r] !== 1'b1 || bus.read_value[r] !== 32'h0 || bus.read_rs_id[r] !== 5'd0) begin
        n_fail++;
        $display("FAIL reset_midop %0d: got valid=%b value=%h rs=%0d, expected 1/0/0", r,
                 bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r]);
      end
    end
  endtask

  function automatic logic [9:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return 10'd1;
      2:       return 10'd8;
      3:       return 10'd9;
      default: return 10'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic test_random();
    logic ev, eerr;
    logic [31:0] ed;
    logic [RW-1:0] et;
    idle();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 300; c++) begin
      idle();
      rst = ($urandom_range(0, 63) == 0);
      bus.flush = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < RP; r++) bus.read_addr[r] = rand_addr();
      for (int w = 0; w < WP; w++) begin
        bus.write_enable[w] = ($urandom_range(0, 1) == 1);
        bus.write_addr[w]   = rand_addr();
        bus.write_rs_id[w]  = RW'($urandom_range(0, 3));
        bus.write_value[w]  = $urandom;
      end
      for (int u = 0; u < UP; u++) begin
        bus.update_enable[u] = ($urandom_range(0, 2) == 0);
        bus.update_addr[u]   = rand_addr();
        bus.update_rs_id[u]  = RW'($urandom_range(0, 3));
      end
      #1;
      $display("txn rand %0d: rst=%b flush=%b rd=%0d/%0d/%0d wr0=%b@%0d t%0d wr1=%b@%0d t%0d up0=%b@%0d t%0d up1=%b@%0d t%0d",
               c, rst, bus.flush, bus.read_addr[0], bus.read_addr[1], bus.read_addr[2],
               bus.write_enable[0], bus.write_addr[0], bus.write_rs_id[0],
               bus.write_enable[1], bus.write_addr[1], bus.write_rs_id[1],
               bus.update_enable[0], bus.update_addr[0], bus.update_rs_id[0],
               bus.update_enable[1], bus.update_addr[1], bus.update_rs_id[1]);
      for (int r = 0; r < RP; r++) begin
        model_read(bus.read_addr[r], ev, ed, et, eerr);
        n_checks++;
        if (bus.read_value_valid[r] !== ev || bus.read_value[r] !== ed ||
            bus.read_rs_id[r] !== et || bus.read_addr_err[r] !== eerr) begin
          n_fail++;
          $display("FAIL rand_read c%0d p%0d addr %0d: got %b/%h/%0d/%b, expected %b/%h/%0d/%b", c, r, bus.read_addr[r],
                   bus.read_value_valid[r], bus.read_value[r], bus.read_rs_id[r], bus.read_addr_err[r], ev, ed, et, eerr);
        end
      end
      for (int u = 0; u < UP; u++) begin
        n_checks++;
        if (bus.update_addr_err[u] !== (bus.update_enable[u] && slot(bus.update_addr[u]) < 0)) begin
          n_fail++;
          $display("FAIL rand_update_err c%0d p%0d: got %b, expected %b", c, u, bus.update_addr_err[u],
                   (bus.update_enable[u] && slot(bus.update_addr[u]) < 0));
        end
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_bypass();
    test_stale_tag();
    test_write_update_same_cycle();
    test_port_priority();
    test_flush_reset_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
